// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU controller and its M-extension sequencer.
`timescale 1ns/1ps
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_ALU = 2'b10;
    localparam logic [1:0] ALUOP_JMP = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SRA = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_BNE = 4'b1001,
        OP_SUB = 4'b1010,
        OP_BGE = 4'b1011,
        OP_SLT = 4'b1100,
        OP_BLT = 4'b1110
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational decode of ALUOp/Funct3/Funct7 into the ALU operation, illegal flag and M-op flag.
`timescale 1ns/1ps
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [1:0] ALUOp,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    input  logic       is_rtype,
    output alu_op_e    Operation,
    output logic       illegal,
    output logic       is_mop
);

    logic f7_chk;
    logic f7_zero;
    logic f7_alt;

    always_comb begin
        Operation = OP_ADD;
        illegal   = 1'b0;
        is_mop    = 1'b0;
        // Immediate forms carry imm[11:5] in Funct7, so only shifts look at it there.
        f7_chk    = is_rtype || (Funct3 == 3'b001) || (Funct3 == 3'b101);
        f7_zero   = (Funct7 == F7_BASE);
        f7_alt    = (Funct7 == F7_ALT);

        case (ALUOp)
            ALUOP_BR: begin
                case (Funct3)
                    3'b001:  Operation = OP_BNE;
                    3'b100:  Operation = OP_BLT;
                    3'b101:  Operation = OP_BGE;
                    default: Operation = OP_BEQ;
                endcase
            end
            ALUOP_ALU: begin
                if (is_rtype && (Funct7 == F7_MULDIV)) begin
                    is_mop  = EN_M;
                    illegal = !EN_M;
                end else begin
                    case (Funct3)
                        3'b000: begin
                            if (is_rtype && f7_alt)        Operation = OP_SUB;
                            else if (!is_rtype || f7_zero) Operation = OP_ADD;
                            else                           illegal   = 1'b1;
                        end
                        3'b001: begin
                            if (f7_zero) Operation = OP_SLL;
                            else         illegal   = 1'b1;
                        end
                        3'b010: begin
                            if (!f7_chk || f7_zero) Operation = OP_SLT;
                            else                    illegal   = 1'b1;
                        end
                        3'b100: begin
                            if (!f7_chk || f7_zero) Operation = OP_XOR;
                            else                    illegal   = 1'b1;
                        end
                        3'b101: begin
                            if (f7_zero)     Operation = OP_SRL;
                            else if (f7_alt) Operation = OP_SRA;
                            else             illegal   = 1'b1;
                        end
                        3'b110: begin
                            if (!f7_chk || f7_zero) Operation = OP_OR;
                            else                    illegal   = 1'b1;
                        end
                        3'b111: begin
                            if (!f7_chk || f7_zero) Operation = OP_AND;
                            else                    illegal   = 1'b1;
                        end
                        default: illegal = 1'b1;
                    endcase
                    if (illegal) Operation = OP_ADD;
                end
            end
            default: Operation = OP_ADD;
        endcase
    end

endmodule

// File: rtl/alu_md_controller.sv
// EX-stage ALU controller: operation decode plus a fixed-latency MUL/DIV sequencer that stalls the
// pipeline, starts/aborts the MDU and steers the MDU result onto the EX output.
`timescale 1ns/1ps
module alu_md_controller
    import alu_ctrl_pkg::*;
#(
    parameter bit          EN_M      = 1'b1,
    parameter int unsigned MUL_LAT   = 4,
    parameter int unsigned DIV_LAT   = 33,
    parameter bit          FAST_DIV0 = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ALUOp,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    input  logic       is_rtype,
    input  logic       ex_valid,
    input  logic       rs2_zero,
    input  logic       flush,
    output alu_op_e    Operation,
    output logic       illegal,
    output logic       stall,
    output logic       md_start,
    output md_op_e     md_op,
    output logic       md_abort,
    output logic       res_sel
);

    localparam int unsigned MAX_LAT = max_u(MUL_LAT, DIV_LAT);
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

    logic             is_mop;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           md_op_q, md_op_d;
    logic             md_start_q, md_start_d;
    logic             res_sel_q, res_sel_d;
    logic             stall_c, abort_c;

    alu_op_decode #(
        .EN_M (EN_M)
    ) u_decode (
        .ALUOp     (ALUOp),
        .Funct7    (Funct7),
        .Funct3    (Funct3),
        .is_rtype  (is_rtype),
        .Operation (Operation),
        .illegal   (illegal),
        .is_mop    (is_mop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            md_op_q    <= MD_MUL;
            md_start_q <= 1'b0;
            res_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_op_q    <= md_op_d;
            md_start_q <= md_start_d;
            res_sel_q  <= res_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_op_d    = md_op_q;
        md_start_d = 1'b0;
        res_sel_d  = 1'b0;
        stall_c    = 1'b0;
        abort_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid && is_mop && !flush) begin
                    stall_c    = 1'b1;
                    state_d    = BUSY;
                    md_start_d = 1'b1;
                    md_op_d    = md_op_e'(Funct3);
                    if (!Funct3[2])                 cnt_d = MUL_INIT;
                    else if (FAST_DIV0 && rs2_zero) cnt_d = '0;
                    else                            cnt_d = DIV_INIT;
                end
            end
            BUSY: begin
                if (flush) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == '0) begin
                        state_d   = DONE;
                        res_sel_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                abort_c = flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces the FSM to IDLE, but an M-op sitting in EX must not stall while reset is held.
    assign stall    = rst_n & stall_c;
    assign md_abort = rst_n & abort_c;
    assign md_start = md_start_q;
    assign md_op    = md_op_q;
    assign res_sel  = res_sel_q;

endmodule

// File: tb/tb_alu_md_controller.sv
// Directed bench for alu_md_controller: decode table, MUL/DIV sequencing, flush and reset behaviour.
`timescale 1ns/1ps
module tb_alu_md_controller;
    import alu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ALUOp;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic       is_rtype, ex_valid, rs2_zero, flush;

    alu_op_e Operation, nm_Operation;
    md_op_e  md_op, nm_md_op;
    logic    illegal, stall, md_start, md_abort, res_sel;
    logic    nm_illegal, nm_stall, nm_md_start, nm_md_abort, nm_res_sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_md_controller dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .is_rtype(is_rtype), .ex_valid(ex_valid), .rs2_zero(rs2_zero), .flush(flush),
        .Operation(Operation), .illegal(illegal), .stall(stall), .md_start(md_start),
        .md_op(md_op), .md_abort(md_abort), .res_sel(res_sel)
    );

    alu_md_controller #(.EN_M(1'b0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .is_rtype(is_rtype), .ex_valid(ex_valid), .rs2_zero(rs2_zero), .flush(flush),
        .Operation(nm_Operation), .illegal(nm_illegal), .stall(nm_stall),
        .md_start(nm_md_start), .md_op(nm_md_op), .md_abort(nm_md_abort), .res_sel(nm_res_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ALUOp = 2'b00; Funct7 = 7'h00; Funct3 = 3'b000;
        is_rtype = 1'b0; ex_valid = 1'b0; rs2_zero = 1'b0; flush = 1'b0;
    endtask

    task automatic drive_mop(input logic [2:0] f3, input logic rz);
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3;
        is_rtype = 1'b1; ex_valid = 1'b1; rs2_zero = rz; flush = 1'b0;
    endtask

    // Cycle 0 is the accept cycle; DONE (res_sel=1, stall=0) is expected at done_cyc.
    task automatic run_md(input string tag, input logic [2:0] f3, input logic rz, input int done_cyc);
        drive_mop(f3, rz);
        for (int c = 0; c <= done_cyc; c++) begin
            @(negedge clk);
            check({tag, "_stall"},    32'(stall),    32'(c < done_cyc));
            check({tag, "_md_start"}, 32'(md_start), 32'(c == 1));
            check({tag, "_res_sel"},  32'(res_sel),  32'(c == done_cyc));
            check({tag, "_md_abort"}, 32'(md_abort), 32'd0);
            check({tag, "_nm_stall"}, 32'(nm_stall), 32'd0);
            check({tag, "_nm_ill"},   32'(nm_illegal), 32'd1);
            if (c == 1) check({tag, "_md_op"}, 32'(md_op), 32'(f3));
            next_cycle();
        end
        ex_valid = 1'b0;
        @(negedge clk);
        check({tag, "_res_sel_clr"}, 32'(res_sel), 32'd0);
        check({tag, "_stall_after"}, 32'(stall),   32'd0);
        next_cycle();
    endtask

    typedef struct packed {
        logic [1:0] aluop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       rt;
        logic [3:0] op;
        logic       ill;
    } dvec_t;

    dvec_t vecs [0:23];
    logic  seen_res_sel;

    initial begin
        vecs = '{
            '{2'b10, 7'h00, 3'b000, 1'b1, 4'b0010, 1'b0},  // ADD
            '{2'b10, 7'h20, 3'b000, 1'b1, 4'b1010, 1'b0},  // SUB
            '{2'b10, 7'h20, 3'b101, 1'b1, 4'b0111, 1'b0},  // SRA
            '{2'b10, 7'h20, 3'b000, 1'b0, 4'b0010, 1'b0},  // ADDI imm[11:5]=0100000
            '{2'b10, 7'h7f, 3'b000, 1'b1, 4'b0010, 1'b1},
            '{2'b10, 7'h20, 3'b101, 1'b0, 4'b0111, 1'b0},  // SRAI
            '{2'b10, 7'h00, 3'b101, 1'b0, 4'b0101, 1'b0},  // SRLI
            '{2'b10, 7'h7f, 3'b101, 1'b0, 4'b0010, 1'b1},
            '{2'b10, 7'h00, 3'b001, 1'b0, 4'b0100, 1'b0},  // SLLI
            '{2'b10, 7'h20, 3'b001, 1'b1, 4'b0010, 1'b1},
            '{2'b10, 7'h00, 3'b111, 1'b1, 4'b0000, 1'b0},  // AND
            '{2'b10, 7'h00, 3'b110, 1'b1, 4'b0001, 1'b0},  // OR
            '{2'b10, 7'h20, 3'b100, 1'b0, 4'b0011, 1'b0},  // XORI, Funct7 ignored
            '{2'b10, 7'h20, 3'b100, 1'b1, 4'b0010, 1'b1},
            '{2'b10, 7'h00, 3'b010, 1'b1, 4'b1100, 1'b0},  // SLT
            '{2'b10, 7'h55, 3'b010, 1'b0, 4'b1100, 1'b0},  // SLTI, Funct7 ignored
            '{2'b01, 7'h00, 3'b000, 1'b0, 4'b1000, 1'b0},  // BEQ
            '{2'b01, 7'h00, 3'b001, 1'b0, 4'b1001, 1'b0},  // BNE
            '{2'b01, 7'h00, 3'b100, 1'b0, 4'b1110, 1'b0},  // BLT
            '{2'b01, 7'h00, 3'b101, 1'b0, 4'b1011, 1'b0},  // BGE
            '{2'b01, 7'h00, 3'b110, 1'b0, 4'b1000, 1'b0},  // other branch -> BEQ
            '{2'b00, 7'h20, 3'b101, 1'b1, 4'b0010, 1'b0},  // LW/SW/AUIPC
            '{2'b11, 7'h7f, 3'b001, 1'b1, 4'b0010, 1'b0},  // JAL/LUI
            '{2'b10, 7'h01, 3'b100, 1'b1, 4'b0010, 1'b0}   // M-op, legal with EN_M=1
        };

        rst_n = 1'b0;
        idle_inputs();
        #7;
        check("rst_md_start", 32'(md_start), 32'd0);
        check("rst_res_sel",  32'(res_sel),  32'd0);
        check("rst_md_op",    32'(md_op),    32'd0);
        check("rst_stall",    32'(stall),    32'd0);
        check("rst_md_abort", 32'(md_abort), 32'd0);
        #5 rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 24; i++) begin
            ALUOp = vecs[i].aluop; Funct7 = vecs[i].f7; Funct3 = vecs[i].f3;
            is_rtype = vecs[i].rt;
            @(negedge clk);
            check($sformatf("dec%0d_op", i),  32'(Operation), 32'(vecs[i].op));
            check($sformatf("dec%0d_ill", i), 32'(illegal),   32'(vecs[i].ill));
            check($sformatf("dec%0d_stall", i), 32'(stall),   32'd0);
            next_cycle();
        end
        // Same M-op encoding without the extension.
        @(negedge clk);
        check("nm_mop_ill", 32'(nm_illegal),   32'd1);
        check("nm_mop_op",  32'(nm_Operation), 32'(OP_ADD));
        next_cycle();
        idle_inputs();

        run_md("mul", 3'b000, 1'b0, 5);
        run_md("div0", 3'b100, 1'b1, 2);
        run_md("div", 3'b100, 1'b0, 34);
        run_md("remu", 3'b111, 1'b0, 34);

        // Flush in IDLE blocks acceptance without aborting.
        drive_mop(3'b000, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("fidle_stall", 32'(stall),    32'd0);
        check("fidle_abort", 32'(md_abort), 32'd0);
        next_cycle();
        flush = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        check("fidle_start", 32'(md_start), 32'd0);
        next_cycle();

        // Flush at BUSY cycle 10 of a DIV.
        drive_mop(3'b100, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("fbusy_stall%0d", c), 32'(stall), 32'd1);
            next_cycle();
        end
        flush = 1'b1;
        @(negedge clk);
        check("fbusy_abort", 32'(md_abort), 32'd1);
        check("fbusy_stall", 32'(stall),    32'd0);
        next_cycle();
        flush = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        check("fbusy_idle_stall", 32'(stall),    32'd0);
        check("fbusy_idle_abort", 32'(md_abort), 32'd0);
        check("fbusy_idle_start", 32'(md_start), 32'd0);
        seen_res_sel = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            seen_res_sel = seen_res_sel | res_sel | stall;
            next_cycle();
        end
        check("fbusy_no_res_sel", 32'(seen_res_sel), 32'd0);

        // Reset asserted in the middle of a MULH.
        drive_mop(3'b001, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rmid_md_op_pre", 32'(md_op), 32'd1);
        check("rmid_stall_pre", 32'(stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_md_start", 32'(md_start), 32'd0);
        check("rmid_res_sel",  32'(res_sel),  32'd0);
        check("rmid_md_op",    32'(md_op),    32'd0);
        check("rmid_stall",    32'(stall),    32'd0);
        check("rmid_abort",    32'(md_abort), 32'd0);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();
        run_md("mul_post_rst", 3'b000, 1'b0, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
